// File: rtl/alu_seq_pkg.sv
// Shared constants and types for the ALU instruction sequencer.
// Instruction layout: {opcode[1:0], a[7:0], b[7:0]}.
package alu_seq_pkg;

    localparam int unsigned INSTR_W = 18;
    localparam int unsigned DATA_W  = 8;

    localparam int unsigned OPC_MSB = 17;
    localparam int unsigned A_MSB   = 15;
    localparam int unsigned B_MSB   = 7;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_XOR  = 2'b01;
    localparam logic [1:0] OP_NAND = 2'b10;
    localparam logic [1:0] OP_FUNC = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2
    } seq_state_e;

    function automatic logic [1:0] instr_opcode(input logic [INSTR_W-1:0] instr);
        return instr[OPC_MSB -: 2];
    endfunction

endpackage

// File: rtl/alu_instr_sequencer_fifo.sv
// Synchronous instruction FIFO; occupancy is kept in a separate counter
// so the naturally wrapping pointers never need an extra full/empty bit.
module instr_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 18,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign count_o = count_q;
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/alu_instr_sequencer.sv
// Issue stage: buffers instructions, feeds the FIFO head to the external
// combinational ALU and registers its result for a downstream handshake.
module alu_instr_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16,
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    output logic [INSTR_W-1:0] alu_instr,
    input  logic [DATA_W-1:0]  alu_result,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [1:0]         out_opcode,
    output logic [CW-1:0]      fifo_count,
    output logic [CNT_W-1:0]   issued_count
);

    seq_state_e         state_q, state_d;
    logic               out_valid_q, out_valid_d;
    logic [DATA_W-1:0]  out_data_q, out_data_d;
    logic [1:0]         out_opcode_q, out_opcode_d;
    logic [CNT_W-1:0]   issued_q, issued_d;

    logic               fifo_full;
    logic               fifo_empty;
    logic [INSTR_W-1:0] head;
    logic               push_c;
    logic               issue_c;

    // Push decision uses registered occupancy only: no same-cycle pop bypass.
    assign in_ready = !fifo_full;
    assign push_c   = in_valid && in_ready;
    assign issue_c  = !fifo_empty && (!out_valid_q || out_ready);

    instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INSTR_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_c),
        .pop_i   (issue_c),
        .wdata_i (in_instr),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign alu_instr    = head;
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_opcode   = out_opcode_q;
    assign issued_count = issued_q;

    always_comb begin
        state_d      = state_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_opcode_d = out_opcode_q;
        issued_d     = issued_q;

        if (issue_c) begin
            out_valid_d  = 1'b1;
            out_data_d   = alu_result;
            out_opcode_d = instr_opcode(head);
            issued_d     = issued_q + CNT_W'(1);
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (push_c) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (out_valid_q && !out_ready) begin
                    state_d = ST_STALL;
                end else if (fifo_empty && !push_c) begin
                    state_d = ST_IDLE;
                end
            end
            ST_STALL: begin
                if (out_ready) state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_opcode_q <= '0;
            issued_q     <= '0;
        end else begin
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_opcode_q <= out_opcode_d;
            issued_q     <= issued_d;
        end
    end

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Directed bench for alu_instr_sequencer: a reference ALU closes the loop,
// a scoreboard queue tracks expected {opcode, result} pairs in issue order.
module tb_alu_instr_sequencer;
    import alu_seq_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [INSTR_W-1:0] in_instr = '0;
    logic [INSTR_W-1:0] alu_instr;
    logic [DATA_W-1:0]  alu_result;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [DATA_W-1:0]  out_data;
    logic [1:0]         out_opcode;
    logic [CW-1:0]      fifo_count;
    logic [CNT_W-1:0]   issued_count;

    int n_cmp = 0;
    int n_err = 0;
    logic [9:0] sb_q[$];

    alu_instr_sequencer #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .alu_instr    (alu_instr),
        .alu_result   (alu_result),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_opcode   (out_opcode),
        .fifo_count   (fifo_count),
        .issued_count (issued_count)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_ref(input logic [INSTR_W-1:0] ins);
        logic [7:0] a;
        logic [7:0] b;
        a = ins[A_MSB -: 8];
        b = ins[B_MSB -: 8];
        case (ins[OPC_MSB -: 2])
            OP_ADD:  return a + b;
            OP_XOR:  return a ^ b;
            OP_NAND: return ~(a & b);
            OP_FUNC: return a - b;
            default: return 8'h00;
        endcase
    endfunction

    assign alu_result = alu_ref(alu_instr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: record accepted instructions, compare results as they leave.
    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready)
                sb_q.push_back({in_instr[OPC_MSB -: 2], alu_ref(in_instr)});
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_result", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    logic [9:0] e;
                    e = sb_q.pop_front();
                    check("sb_result", 32'({out_opcode, out_data}), 32'(e));
                end
            end
        end
    end

    task automatic send(input logic [INSTR_W-1:0] ins);
        logic acc;
        acc = 1'b0;
        in_valid = 1'b1;
        in_instr = ins;
        for (int i = 0; i < 40 && !acc; i++) begin
            acc = in_ready;
            tick();
        end
        check("send_accepted", 32'(acc), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            if (sb_q.size() == 0 && !out_valid) done = 1'b1;
            else tick();
        end
        check("drain_done", 32'(done), 32'd1);
    endtask

    function automatic logic [INSTR_W-1:0] mk(input logic [1:0] op, input logic [7:0] a,
                                             input logic [7:0] b);
        return {op, a, b};
    endfunction

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_fifo_count", 32'(fifo_count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_opcode", 32'(out_opcode), 32'd0);
        check("rst_issued", 32'(issued_count), 32'd0);
        check("rst_alu_instr", 32'(alu_instr), 32'd0);
        rst = 1'b0;
        tick();

        // Single add: result one edge after acceptance
        out_ready = 1'b1;
        send(mk(OP_ADD, 8'h20, 8'h1F));
        check("add_fifo_count", 32'(fifo_count), 32'd1);
        check("add_alu_instr", 32'(alu_instr), 32'(mk(OP_ADD, 8'h20, 8'h1F)));
        check("add_not_yet_valid", 32'(out_valid), 32'd0);
        tick();
        check("add_out_valid", 32'(out_valid), 32'd1);
        check("add_out_data", 32'(out_data), 32'h3F);
        check("add_out_opcode", 32'(out_opcode), 32'd0);
        check("add_issued", 32'(issued_count), 32'd1);
        tick();
        check("add_drained", 32'(out_valid), 32'd0);

        // Back-to-back: one result per cycle
        send(mk(OP_XOR, 8'h01, 8'h00));
        send(mk(OP_NAND, 8'hAA, 8'h55));
        check("b2b_xor", 32'(out_data), 32'h01);
        send(mk(OP_FUNC, 8'h1F, 8'h11));
        check("b2b_nand", 32'(out_data), 32'hFF);
        tick();
        check("b2b_func", 32'(out_data), 32'h0E);
        check("b2b_func_opc", 32'(out_opcode), 32'd3);
        check("b2b_issued", 32'(issued_count), 32'd4);
        wait_drain();

        // Backpressure until full, then release
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            send(mk(2'(i), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))));
        check("full_count", 32'(fifo_count), 32'd4);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_out_valid", 32'(out_valid), 32'd1);
        check("full_issued", 32'(issued_count), 32'd5);
        in_valid = 1'b1;
        in_instr = mk(OP_FUNC, 8'h80, 8'h7F);
        tick();
        tick();
        check("full_hold_count", 32'(fifo_count), 32'd4);
        check("full_hold_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        tick();
        check("full_refuse_on_pop", 32'(fifo_count), 32'd3);
        check("full_ready_back", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("full_push_pop_count", 32'(fifo_count), 32'd3);
        wait_drain();
        check("full_after_ready", 32'(in_ready), 32'd1);
        check("full_after_count", 32'(fifo_count), 32'd0);
        check("full_after_issued", 32'(issued_count), 32'd10);

        // Simultaneous push and pop at occupancy two
        out_ready = 1'b0;
        send(mk(OP_ADD, 8'h11, 8'h22));
        send(mk(OP_XOR, 8'h33, 8'h44));
        send(mk(OP_NAND, 8'h55, 8'h66));
        check("pp_pre_count", 32'(fifo_count), 32'd2);
        out_ready = 1'b1;
        send(mk(OP_FUNC, 8'h77, 8'h88));
        check("pp_count", 32'(fifo_count), 32'd2);
        wait_drain();
        check("pp_issued", 32'(issued_count), 32'd14);

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            send(mk(OP_ADD, 8'(i), 8'h10));
        check("mrst_pre_count", 32'(fifo_count), 32'd3);
        check("mrst_pre_issued", 32'(issued_count), 32'd15);
        #2;
        rst = 1'b1;
        #1;
        check("mrst_out_valid", 32'(out_valid), 32'd0);
        check("mrst_fifo_count", 32'(fifo_count), 32'd0);
        check("mrst_issued", 32'(issued_count), 32'd0);
        sb_q.delete();
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        send(mk(OP_ADD, 8'hFF, 8'h01));
        tick();
        check("mrst_new_valid", 32'(out_valid), 32'd1);
        check("mrst_new_data", 32'(out_data), 32'h00);
        check("mrst_new_issued", 32'(issued_count), 32'd1);
        wait_drain();

        // Counter wrap at CNT_W=4
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 16; i++)
            send(mk(2'(i), 8'(i * 7), 8'(i * 3)));
        tick();
        check("wrap_16", 32'(issued_count), 32'd0);
        send(mk(OP_XOR, 8'h5A, 8'hA5));
        tick();
        check("wrap_17", 32'(issued_count), 32'd1);
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
